// File: rtl/bcd_seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver.
// Captures a BCD digit pair on i_Load and decodes both digits.
// It shows the ones and tens digits in alternating time slots on a shared, active-low segment bus.
// Each slot opens with a dead time in which both digit selects are off, so the previous digit cannot ghost.
// Brightness is set by PWM gating of the lit portion of each slot.
// A zero tens digit can be blanked.
module bcd_seg7_scan_driver #(
    parameter int CLKS_PER_DIGIT = 25000,
    parameter int DEAD_CLKS      = 2,
    parameter int PWM_BITS       = 4,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic [3:0]          i_BCD1,
    input  logic [3:0]          i_BCD2,
    input  logic                i_Load,
    input  logic [PWM_BITS-1:0] i_Brightness,
    output logic [6:0]          o_Seg,
    output logic [1:0]          o_Dig_Sel,
    output logic                o_Invalid
);

    localparam int CNT_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD_CLKS);

    logic [3:0]          r_D1;
    logic [3:0]          r_D2;
    logic [CNT_W-1:0]    r_Slot_Cnt;
    logic                r_Slot_Tens;
    logic [PWM_BITS-1:0] r_Pwm_Cnt;
    logic [6:0]          r_Seg;
    logic [1:0]          r_Dig_Sel;
    logic                r_Invalid;

    logic                w_Pwm_On;
    logic                w_Blank;
    logic                w_Lit;
    logic [3:0]          w_Digit;
    logic [6:0]          w_Pattern;

    // Active-high segment pattern (bit0=a .. bit6=g); non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    // Decide whether the active digit is lit this cycle and what it shows.
    always_comb begin
        w_Pwm_On  = (r_Pwm_Cnt < i_Brightness) || (&i_Brightness);
        w_Blank   = (BLANK_LEADING != 0) && r_Slot_Tens && (r_D2 == 4'd0);
        w_Lit     = (r_Slot_Cnt >= DEAD_END) && w_Pwm_On && !w_Blank;
        w_Digit   = r_Slot_Tens ? r_D2 : r_D1;
        w_Pattern = seg_decode(w_Digit);
    end

    // Digit capture; reset takes priority over a simultaneous load.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_D1 <= 4'd0;
            r_D2 <= 4'd0;
        end else if (i_Load) begin
            r_D1 <= i_BCD1;
            r_D2 <= i_BCD2;
        end
    end

    // Free-running slot timer, slot toggle, and PWM counter.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Slot_Cnt  <= '0;
            r_Slot_Tens <= 1'b0;
            r_Pwm_Cnt   <= '0;
        end else begin
            r_Pwm_Cnt <= r_Pwm_Cnt + 1'b1;
            if (r_Slot_Cnt == SLOT_LAST) begin
                r_Slot_Cnt  <= '0;
                r_Slot_Tens <= !r_Slot_Tens;
            end else begin
                r_Slot_Cnt <= r_Slot_Cnt + 1'b1;
            end
        end
    end

    // Registered pin drivers; at most one select is ever low because only the active slot is enabled.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Seg     <= 7'h7F;
            r_Dig_Sel <= 2'b11;
            r_Invalid <= 1'b0;
        end else begin
            r_Invalid <= (r_D1 > 4'd9) || (r_D2 > 4'd9);
            if (w_Lit) begin
                r_Seg     <= ~w_Pattern;
                r_Dig_Sel <= r_Slot_Tens ? 2'b01 : 2'b10;
            end else begin
                r_Seg     <= 7'h7F;
                r_Dig_Sel <= 2'b11;
            end
        end
    end

    assign o_Seg     = r_Seg;
    assign o_Dig_Sel = r_Dig_Sel;
    assign o_Invalid = r_Invalid;

endmodule

// File: tb/tb_bcd_seg7_scan_driver.sv
// Scoreboard bench for bcd_seg7_scan_driver.
// Two instances share all inputs: one blanks the leading zero and one does not.
// The reference model derives slot, dead time and PWM phase arithmetically from the cycle count since reset.
module tb_bcd_seg7_scan_driver;

    localparam int CPD   = 8;
    localparam int DEAD  = 2;
    localparam int PB    = 2;
    localparam int PWMN  = 1 << PB;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic [3:0]    bcd1 = 4'd0;
    logic [3:0]    bcd2 = 4'd0;
    logic          load = 1'b0;
    logic [PB-1:0] bright = '0;

    logic [6:0] seg_b, seg_n;
    logic [1:0] sel_b, sel_n;
    logic       inv_b, inv_n;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_seg7_scan_driver #(
        .CLKS_PER_DIGIT(CPD), .DEAD_CLKS(DEAD), .PWM_BITS(PB), .BLANK_LEADING(1)
    ) u_dut_blank (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_BCD1(bcd1), .i_BCD2(bcd2), .i_Load(load),
        .i_Brightness(bright), .o_Seg(seg_b), .o_Dig_Sel(sel_b), .o_Invalid(inv_b)
    );

    bcd_seg7_scan_driver #(
        .CLKS_PER_DIGIT(CPD), .DEAD_CLKS(DEAD), .PWM_BITS(PB), .BLANK_LEADING(0)
    ) u_dut_noblank (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_BCD1(bcd1), .i_BCD2(bcd2), .i_Load(load),
        .i_Brightness(bright), .o_Seg(seg_n), .o_Dig_Sel(sel_n), .o_Invalid(inv_n)
    );

    typedef struct {
        logic [6:0] seg_b;
        logic [1:0] sel_b;
        logic [6:0] seg_n;
        logic [1:0] sel_n;
        logic       inv;
    } exp_t;

    exp_t exp_q[$];

    // Segment table, active-high, a..g in bits 0..6.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Model state: cycles since reset release and the last captured digits.
    int tc = 0;
    int md1 = 0;
    int md2 = 0;

    function automatic void model_out(input int t, input int d1, input int d2, input int br,
                                      input bit blank, output logic [6:0] seg,
                                      output logic [1:0] sel);
        int  pos;
        bit  tens;
        bit  on;
        bit  lit;
        pos  = t % CPD;
        tens = ((t / CPD) % 2) == 1;
        on   = ((t % PWMN) < br) || (br == PWMN - 1);
        lit  = (pos >= DEAD) && on && !(tens && blank && d2 == 0);
        if (lit) begin
            seg = ~seg_tab[tens ? d2 : d1];
            sel = tens ? 2'b01 : 2'b10;
        end else begin
            seg = 7'h7F;
            sel = 2'b11;
        end
    endfunction

    // Model: at each rising edge predict the outputs the DUT registers at that edge.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_l) begin
            e.seg_b = 7'h7F; e.sel_b = 2'b11;
            e.seg_n = 7'h7F; e.sel_n = 2'b11;
            e.inv   = 1'b0;
            tc = 0; md1 = 0; md2 = 0;
        end else begin
            model_out(tc, md1, md2, int'(bright), 1'b1, e.seg_b, e.sel_b);
            model_out(tc, md1, md2, int'(bright), 1'b0, e.seg_n, e.sel_n);
            e.inv = (md1 > 9) || (md2 > 9);
            tc++;
            if (load) begin
                md1 = int'(bcd1);
                md2 = int'(bcd2);
            end
        end
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compare on the falling edge, away from the registering edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("seg_blank",   {1'b0, seg_b}, {1'b0, e.seg_b});
            chk("sel_blank",   {6'd0, sel_b}, {6'd0, e.sel_b});
            chk("inv_blank",   {7'd0, inv_b}, {7'd0, e.inv});
            chk("seg_noblank", {1'b0, seg_n}, {1'b0, e.seg_n});
            chk("sel_noblank", {6'd0, sel_n}, {6'd0, e.sel_n});
            chk("inv_noblank", {7'd0, inv_n}, {7'd0, e.inv});
            chk("sel_not_both_low", {7'd0, (sel_b == 2'b00) || (sel_n == 2'b00)}, 8'd0);
        end
    end

    // Apply one clock's worth of inputs, changed on the falling edge.
    task automatic step(input bit rl, input bit ld, input int d1, input int d2, input int br);
        @(negedge clk);
        rst_l  = rl;
        load   = ld;
        bcd1   = 4'(d1);
        bcd2   = 4'(d2);
        bright = PB'(br);
    endtask

    task automatic idle(input int n, input int br);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, br);
    endtask

    initial begin
        // Reset held with a load pending; the load must be ignored.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 7, 4, 3);
        idle(20, 3);
        // Ordinary digits at full brightness.
        step(1'b1, 1'b1, 7, 4, 3);
        idle(40, 3);
        // Leading zero: blanked on one instance only.
        step(1'b1, 1'b1, 5, 0, 3);
        idle(32, 3);
        // Low and zero brightness.
        idle(32, 1);
        idle(32, 0);
        idle(8, 2);
        // Invalid ones digit, then a valid pair clears the flag.
        step(1'b1, 1'b1, 12, 3, 3);
        idle(24, 3);
        step(1'b1, 1'b1, 3, 3, 3);
        idle(24, 3);
        // Invalid tens digit is shown as a dash, not blanked.
        step(1'b1, 1'b1, 9, 15, 3);
        idle(20, 3);
        // Reset in the middle of a lit slot, then a load at the first slot wrap.
        step(1'b0, 1'b0, 0, 0, 3);
        step(1'b0, 1'b0, 0, 0, 3);
        idle(7, 3);
        step(1'b1, 1'b1, 8, 6, 3);
        idle(24, 3);
        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            int br;
            int r;
            br = (i % 97 == 0) ? int'($urandom_range(0, PWMN - 1)) : int'(bright);
            r  = int'($urandom_range(0, 99));
            if (r < 2)
                step(1'b0, $urandom_range(0, 1) == 1, 5, 5, br);
            else if (r < 12)
                step(1'b1, 1'b1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9)),
                     br);
            else
                step(1'b1, 1'b0, 0, 0, br);
        end
        idle(3, 3);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
